// File: rtl/tdes_round_sched_if.sv
// Handshake and control bundle between the DES/3DES round sequencer and the
// blocks around it (request source, round datapath, key schedule, result sink).
//
// Signals:
//   in_valid / in_ready / decrypt : block request handshake and mode
//   abort                         : synchronous abort to IDLE
//   out_valid / out_ready         : result handshake
//   blk_load, ks_load, key_sel    : load strobes and key select
//   round_en, shift_dir, shift_amt, last_round : per-round datapath/key-schedule controls
//   round_idx, pass_idx, busy     : progress status
//
// Modports:
//   master : the environment side (drives requests, abort, out_ready)
//   slave  : the sequencer itself
interface tdes_round_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic       decrypt;
  logic       abort;
  logic       blk_load;
  logic       ks_load;
  logic [1:0] key_sel;
  logic       round_en;
  logic       shift_dir;
  logic [1:0] shift_amt;
  logic       last_round;
  logic [3:0] round_idx;
  logic [1:0] pass_idx;
  logic       busy;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_valid, decrypt, abort, out_ready,
    input  in_ready, blk_load, ks_load, key_sel, round_en, shift_dir,
           shift_amt, last_round, round_idx, pass_idx, busy, out_valid
  );

  modport slave (
    input  in_valid, decrypt, abort, out_ready,
    output in_ready, blk_load, ks_load, key_sel, round_en, shift_dir,
           shift_amt, last_round, round_idx, pass_idx, busy, out_valid
  );
endinterface

// File: rtl/tdes_round_sched.sv
// Sequencer for an iterative single-round DES datapath and its C/D key
// schedule. One accepted block is stepped through 16 rounds per pass; with
// TRIPLE=1 three passes are run in EDE order with a key reload between passes.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   sched  : tdes_round_sched_if.slave bundle (request/result handshakes,
//            load strobes, key select, round enable, shift controls, status)
//
// Parameters:
//   TRIPLE : 1 = 3DES EDE (3 passes), 0 = single DES (1 pass, K1 only)
//
// All outputs are Moore outputs decoded from the state, counters and the
// mode latched at accept time.
module tdes_round_sched #(
  parameter bit TRIPLE = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  tdes_round_sched_if.slave   sched
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    KEYLD = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] LAST_PASS = TRIPLE ? 2'd2 : 2'd0;

  state_t     state_reg;
  logic [3:0] round_idx_reg;
  logic [1:0] pass_idx_reg;
  logic       mode_reg;

  // Encryption key-schedule rotation amount for round r.
  function automatic logic [1:0] shift_of(input logic [3:0] r);
    logic [1:0] amt;
    case (r)
      4'd0, 4'd1, 4'd8, 4'd15: amt = 2'd1;
      default:                 amt = 2'd2;
    endcase
    return amt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      round_idx_reg <= 4'd0;
      pass_idx_reg  <= 2'd0;
      mode_reg      <= 1'b0;
    end else if (sched.abort) begin
      // Abort wins over both handshakes, including a pending request in IDLE.
      state_reg     <= IDLE;
      round_idx_reg <= 4'd0;
      pass_idx_reg  <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sched.in_valid) begin
            mode_reg      <= sched.decrypt;
            round_idx_reg <= 4'd0;
            pass_idx_reg  <= 2'd0;
            state_reg     <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= ROUND;
        end
        ROUND: begin
          if (round_idx_reg == 4'd15) begin
            if (pass_idx_reg == LAST_PASS) begin
              // round_idx stays at 15 in DONE; it only wraps on a pass change.
              state_reg <= DONE;
            end else begin
              pass_idx_reg  <= pass_idx_reg + 2'd1;
              round_idx_reg <= 4'd0;
              state_reg     <= KEYLD;
            end
          end else begin
            round_idx_reg <= round_idx_reg + 4'd1;
          end
        end
        KEYLD: begin
          state_reg <= ROUND;
        end
        DONE: begin
          if (sched.out_ready) begin
            round_idx_reg <= 4'd0;
            pass_idx_reg  <= 2'd0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Decrypt passes: pass 1 in encrypt mode; passes 0 and 2 in decrypt mode.
  logic pass_is_d;
  assign pass_is_d = TRIPLE ? (mode_reg ^ (pass_idx_reg == 2'd1)) : mode_reg;

  logic in_round;
  assign in_round = (state_reg == ROUND);

  // Decrypt passes rotate right by the encryption table read backwards,
  // with no rotation before round 0. 4'd0 - r is 16 - r for r = 1..15.
  logic [1:0] amt_d;
  assign amt_d = (round_idx_reg == 4'd0) ? 2'd0 : shift_of(4'd0 - round_idx_reg);

  assign sched.in_ready   = (state_reg == IDLE);
  assign sched.busy       = (state_reg != IDLE);
  assign sched.out_valid  = (state_reg == DONE);
  assign sched.blk_load   = (state_reg == LOAD);
  assign sched.ks_load    = (state_reg == LOAD) || (state_reg == KEYLD);
  assign sched.round_en   = in_round;
  assign sched.last_round = in_round && (round_idx_reg == 4'd15);
  assign sched.round_idx  = round_idx_reg;
  assign sched.pass_idx   = pass_idx_reg;
  // Key order K1,K2,K3 for encrypt mode, K3,K2,K1 for decrypt mode.
  assign sched.key_sel    = !TRIPLE ? 2'd0
                          : (mode_reg ? (2'd2 - pass_idx_reg) : pass_idx_reg);
  assign sched.shift_dir  = in_round && pass_is_d;
  assign sched.shift_amt  = !in_round ? 2'd0
                          : (pass_is_d ? amt_d : shift_of(round_idx_reg));

endmodule

// File: tb/tb_tdes_round_sched.sv
module tb_tdes_round_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdes_round_sched_if bus3 ();
  tdes_round_sched_if bus1 ();

  tdes_round_sched #(.TRIPLE(1'b1)) dut3 (.clk(clk), .rst_n(rst_n), .sched(bus3));
  tdes_round_sched #(.TRIPLE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .sched(bus1));

  // Shift-amount sequences over rounds 0..15, copied from the key schedule tables.
  localparam int SE[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SD[16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct packed {
    int          lat;
    int          nks;
    logic [5:0]  ks_sel;
    logic [23:0] ks_pos;
    logic [2:0]  dir;
    logic [95:0] amt;
    int          lr_cnt;
    int          hold;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_seq(input bit dpass);
    logic [31:0] v = '0;
    for (int r = 0; r < 16; r++)
      v[2*r +: 2] = dpass ? SD[r][1:0] : SE[r][1:0];
    return v;
  endfunction

  function automatic exp_t mk_exp(input bit triple, input bit dec, input int h);
    exp_t e;
    logic [31:0] se = pack_seq(1'b0);
    logic [31:0] sd = pack_seq(1'b1);
    e.hold = h;
    if (triple) begin
      e.lat    = 51;
      e.nks    = 3;
      e.ks_pos = {8'd34, 8'd17, 8'd0};
      e.ks_sel = dec ? {2'd0, 2'd1, 2'd2} : {2'd2, 2'd1, 2'd0};
      e.dir    = dec ? 3'b101 : 3'b010;
      e.amt    = dec ? {sd, se, sd} : {se, sd, se};
    end else begin
      e.lat    = 17;
      e.nks    = 1;
      e.ks_pos = 24'd0;
      e.ks_sel = 6'd0;
      e.dir    = {2'b00, dec};
      e.amt    = {64'd0, dec ? sd : se};
    end
    e.lr_cnt = e.nks;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          act[2];
  bit          idle_chk[2];
  bit          dir_bad[2];
  bit          lr_bad[2];
  int          cyc[2];
  int          nks[2];
  int          first_ov[2];
  int          hold[2];
  int          lr_cnt[2];
  logic [5:0]  ks_sel[2];
  logic [23:0] ks_pos[2];
  logic [2:0]  dirv[2];
  logic [95:0] amt[2];

  task automatic mon_step(input int m, input logic bl, input logic kl, input logic [1:0] ks,
                          input logic re, input logic sd, input logic [1:0] sa, input logic lr,
                          input logic [3:0] ri, input logic [1:0] pi, input logic bz,
                          input logic ir, input logic ov, input logic ordy);
    string tag = (m == 0) ? "3des" : "des";
    exp_t e;
    bit have;
    if (bl) begin
      act[m] = 1; cyc[m] = 0; nks[m] = 0; ks_sel[m] = '0; ks_pos[m] = '0;
      dirv[m] = '0; dir_bad[m] = 0; amt[m] = '0; lr_cnt[m] = 0; lr_bad[m] = 0;
      hold[m] = 0; first_ov[m] = -1;
    end else if (act[m]) begin
      cyc[m]++;
    end
    if (act[m]) begin
      if (kl && nks[m] < 3) begin
        ks_sel[m][2*nks[m] +: 2] = ks;
        ks_pos[m][8*nks[m] +: 8] = cyc[m][7:0];
        nks[m]++;
      end
      if (re && pi <= 2'd2) begin
        amt[m][32*pi + 2*ri +: 2] = sa;
        if (ri == 4'd0) dirv[m][pi] = sd;
        else if (dirv[m][pi] !== sd) dir_bad[m] = 1;
      end
      if (lr) begin
        lr_cnt[m]++;
        if (!(re && ri == 4'd15)) lr_bad[m] = 1;
      end
      if (ov) begin
        if (first_ov[m] < 0) first_ov[m] = cyc[m];
        chk($sformatf("%s in_ready in DONE", tag), {95'd0, ir}, 96'd0);
        if (ordy) begin
          have = (m == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          if (!have) begin
            chk($sformatf("%s unexpected out_valid", tag), 96'd1, 96'd0);
          end else begin
            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("%s latency", tag), 96'(first_ov[m]), 96'(e.lat));
            chk($sformatf("%s ks_load count", tag), 96'(nks[m]), 96'(e.nks));
            chk($sformatf("%s ks_load cycles", tag), 96'(ks_pos[m]), 96'(e.ks_pos));
            chk($sformatf("%s key_sel order", tag), 96'(ks_sel[m]), 96'(e.ks_sel));
            chk($sformatf("%s shift_dir per pass", tag), 96'(dirv[m]), 96'(e.dir));
            chk($sformatf("%s shift_dir stable", tag), 96'(dir_bad[m]), 96'd0);
            chk($sformatf("%s shift_amt seq", tag), amt[m], e.amt);
            chk($sformatf("%s last_round count", tag), 96'(lr_cnt[m]), 96'(e.lr_cnt));
            chk($sformatf("%s last_round position", tag), 96'(lr_bad[m]), 96'd0);
            chk($sformatf("%s out_valid hold", tag), 96'(hold[m]), 96'(e.hold));
          end
          $display("[%0t] %s block done: latency=%0d hold=%0d", $time, tag, first_ov[m], hold[m]);
          act[m] = 0;
          idle_chk[m] = 1;
        end else begin
          hold[m]++;
        end
      end
    end else begin
      if (idle_chk[m]) begin
        chk($sformatf("%s idle after take", tag), {93'd0, ir, bz, ov}, {93'd0, 3'b100});
        idle_chk[m] = 0;
      end else if (ov) begin
        chk($sformatf("%s out_valid while idle", tag), 96'd1, 96'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act[0] = 0; act[1] = 0; idle_chk[0] = 0; idle_chk[1] = 0;
      end else begin
        mon_step(0, bus3.blk_load, bus3.ks_load, bus3.key_sel, bus3.round_en, bus3.shift_dir,
                 bus3.shift_amt, bus3.last_round, bus3.round_idx, bus3.pass_idx, bus3.busy,
                 bus3.in_ready, bus3.out_valid, bus3.out_ready);
        mon_step(1, bus1.blk_load, bus1.ks_load, bus1.key_sel, bus1.round_en, bus1.shift_dir,
                 bus1.shift_amt, bus1.last_round, bus1.round_idx, bus1.pass_idx, bus1.busy,
                 bus1.in_ready, bus1.out_valid, bus1.out_ready);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input int m, input logic v, input logic d);
    if (m == 0) begin bus3.in_valid = v; bus3.decrypt = d; end
    else        begin bus1.in_valid = v; bus1.decrypt = d; end
  endtask

  task automatic set_ordy(input int m, input logic v);
    if (m == 0) bus3.out_ready = v;
    else        bus1.out_ready = v;
  endtask

  function automatic logic get_ov(input int m);
    return (m == 0) ? bus3.out_valid : bus1.out_valid;
  endfunction

  // Called and returns at posedge+1.
  task automatic send(input int m, input bit dec, input int h);
    int n = 0;
    if (m == 0) exp_q0.push_back(mk_exp(1'b1, dec, h));
    else        exp_q1.push_back(mk_exp(1'b0, dec, h));
    $display("[%0t] issue %s %s hold=%0d", $time, (m == 0) ? "3des" : "des",
             dec ? "decrypt" : "encrypt", h);
    set_in(m, 1'b1, dec);
    @(posedge clk); #1;
    set_in(m, 1'b0, 1'b0);
    while (!get_ov(m) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!get_ov(m)) begin
      chk("wait out_valid timeout", 96'd1, 96'd0);
    end else begin
      repeat (h) begin @(posedge clk); #1; end
      set_ordy(m, 1'b1);
      @(posedge clk); #1;
      set_ordy(m, 1'b0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_pos(input logic [1:0] p, input logic [3:0] r);
    int n = 0;
    while (!(bus3.round_en && bus3.pass_idx == p && bus3.round_idx == r) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait round position", {95'd0, bus3.round_en && bus3.pass_idx == p && bus3.round_idx == r},
        96'd1);
  endtask

  task automatic chk_idle_outs(input string name);
    chk({name, " 3des status"}, {90'd0, bus3.in_ready, bus3.busy, bus3.out_valid, bus3.pass_idx,
        bus3.round_idx == 4'd0}, {90'd0, 6'b100001});
    chk({name, " 3des strobes"}, {92'd0, bus3.blk_load, bus3.ks_load, bus3.round_en,
        bus3.last_round}, 96'd0);
    chk({name, " des status"}, {93'd0, bus1.in_ready, bus1.busy, bus1.out_valid}, {93'd0, 3'b100});
  endtask

  initial begin
    set_in(0, 1'b0, 1'b0); set_in(1, 1'b0, 1'b0);
    set_ordy(0, 1'b0); set_ordy(1, 1'b0);
    bus3.abort = 1'b0; bus1.abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_idle_outs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal blocks, including a 10-cycle stall in DONE.
    send(0, 1'b0, 0);
    send(0, 1'b1, 10);
    send(1, 1'b0, 0);
    send(1, 1'b1, 2);

    // Asynchronous reset in the middle of pass 1.
    set_in(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    wait_pos(2'd1, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    $display("[%0t] reset asserted mid-round", $time);
    chk_idle_outs("mid-run reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Abort in pass 2, round 3.
    set_in(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    wait_pos(2'd2, 4'd3);
    bus3.abort = 1'b1;
    @(posedge clk); #1;
    bus3.abort = 1'b0;
    $display("[%0t] abort applied", $time);
    chk_idle_outs("abort");
    repeat (60) begin @(posedge clk); #1; end
    send(0, 1'b0, 1);
    send(1, 1'b0, 0);

    // Abort held in IDLE blocks a request.
    bus1.abort = 1'b1;
    set_in(1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("abort in idle busy", {95'd0, bus1.busy}, 96'd0);
    chk("abort in idle in_ready", {95'd0, bus1.in_ready}, 96'd1);
    set_in(1, 1'b0, 1'b0);
    bus1.abort = 1'b0;
    repeat (25) begin @(posedge clk); #1; end

    chk("3des queue drained", 96'(exp_q0.size()), 96'd0);
    chk("des queue drained", 96'(exp_q1.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
